// File: rtl/sd_pkg.sv
// Shared constants, state encoding and helpers for the SD sector-read path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sd_pkg;

  // SD single-block read opcode issued by the downstream read engine.
  localparam logic [7:0] SD_CMD17 = 8'h51;

  // Frame geometry: every stored line is the active pixels plus padding so a
  // line is a whole number of 16-bit words; sectors hold SECTOR_WORDS words.
  localparam int SECTOR_WORDS = 256;
  localparam int LINE_ACTIVE  = 1920;
  localparam int LINE_PAD     = 16;
  localparam int FRAME_LINES  = 1080;
  localparam int FRAME_WORDS  = FRAME_LINES * (LINE_ACTIVE + LINE_PAD);

  // Sectors per frame, rounded up so a partial last sector is still read.
  localparam logic [15:0] SECTORS_PER_FRAME_DEF =
    16'((FRAME_WORDS + SECTOR_WORDS - 1) / SECTOR_WORDS);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FRAME_START = 3'd1,
    ISSUE       = 3'd2,
    WAIT_ACK    = 3'd3,
    WAIT_DONE   = 3'd4,
    NEXT        = 3'd5,
    GAP         = 3'd6,
    DONE        = 3'd7
  } state_e;

  // Base sector of a frame; wraps modulo 2^32.
  function automatic logic [31:0] frame_base(input logic [31:0] start,
                                             input logic [7:0]  idx,
                                             input logic [31:0] stride);
    logic [31:0] idx_w;
    idx_w = {24'd0, idx};
    return start + idx_w * stride;
  endfunction

endpackage

// File: rtl/sd_req_pulse.sv
// Purpose: registers the one-cycle rd_en request and times the wait for rd_busy.
// Latency: rd_en is high the cycle after fire; ack_timeout is combinational.
// Backpressure: fire is only raised by the parent when the FIFO has room.
//
// Ports:
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   fire               : parent is issuing a request this cycle
//   wait_ack           : parent is waiting for rd_busy to rise
//   rd_busy            : read engine busy
//   rd_en              : registered one-cycle read request
//   ack_timeout        : ACK_TIMEOUT cycles spent waiting with no rd_busy
module sd_req_pulse #(
  parameter logic [3:0] ACK_TIMEOUT = 4'd8
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic fire,
  input  logic wait_ack,
  input  logic rd_busy,
  output logic rd_en,
  output logic ack_timeout
);

  logic       rd_en_q, rd_en_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    rd_en_d    = fire;
    wait_cnt_d = 4'd0;
    // Counter only runs while waiting; any other state parks it at zero so a
    // reissue gets the full window again.
    if (wait_ack && !rd_busy) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  assign ack_timeout = wait_ack && !rd_busy && (wait_cnt_q == ACK_TIMEOUT - 4'd1);
  assign rd_en       = rd_en_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rd_en_q    <= 1'b0;
      wait_cnt_q <= 4'd0;
    end else begin
      rd_en_q    <= rd_en_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/sd_frame_rd_ctrl.sv
// Purpose: sequences single-sector reads through stored frames, toggling pic_c per frame.
// Latency: first rd_en of a frame 2 cycles after the pic_c toggle; one request in flight.
// Backpressure: holds in ISSUE while fifo_afull; frames start only on a pending frame_req.
//
// Ports:
//   sys_clk, sys_rst_n     : clock, synchronous active-low reset
//   init_end, play_en      : card ready / playback enable (levels)
//   frame_req              : one-cycle pulse, downstream wants the next frame
//   fifo_afull, rd_busy    : downstream FIFO almost full / read engine busy
//   rd_en, rd_addr         : one-cycle read request and its sector address
//   pic_c, frame_idx       : frame-switch flag and current frame index
//   frame_done, ctrl_busy  : end-of-frame pulse / state != IDLE
// Build option: define SD_RD_LOOP_EN to loop playback after the last frame;
// otherwise the block parks in DONE until play_en falls.
module sd_frame_rd_ctrl
  import sd_pkg::*;
#(
  parameter logic [31:0] START_SECTOR      = 32'h0000_4000,
  parameter logic [15:0] SECTORS_PER_FRAME = SECTORS_PER_FRAME_DEF,
  parameter logic [31:0] FRAME_STRIDE      = 32'd8192,
  parameter logic [7:0]  NUM_FRAMES        = 8'd1,
  parameter logic [3:0]  ACK_TIMEOUT       = 4'd8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic        play_en,
  input  logic        frame_req,
  input  logic        fifo_afull,
  input  logic        rd_busy,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  output logic        pic_c,
  output logic [7:0]  frame_idx,
  output logic        frame_done,
  output logic        ctrl_busy
);

  state_e      state_q, state_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [15:0] sec_cnt_q, sec_cnt_d;
  logic [7:0]  frame_idx_q, frame_idx_d;
  logic        pic_c_q, pic_c_d;
  logic        frame_done_q, frame_done_d;
  logic        req_pend_q, req_pend_d;

  logic        fire;
  logic        ack_timeout;
  logic        last_frame;

  assign fire       = (state_q == ISSUE) && !fifo_afull;
  assign last_frame = (frame_idx_q == NUM_FRAMES - 8'd1);

  sd_req_pulse #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_req_pulse (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .fire        (fire),
    .wait_ack    (state_q == WAIT_ACK),
    .rd_busy     (rd_busy),
    .rd_en       (rd_en),
    .ack_timeout (ack_timeout)
  );

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    sec_cnt_d    = sec_cnt_q;
    frame_idx_d  = frame_idx_q;
    pic_c_d      = pic_c_q;
    frame_done_d = 1'b0;
    req_pend_d   = req_pend_q;

    case (state_q)
      IDLE: begin
        if (init_end && play_en && req_pend_q) state_d = FRAME_START;
      end
      FRAME_START: begin
        state_d = ISSUE;
      end
      ISSUE: begin
        if (!fifo_afull) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (rd_busy)          state_d = WAIT_DONE;
        else if (ack_timeout) state_d = ISSUE;   // reissue, address unchanged
      end
      WAIT_DONE: begin
        if (!rd_busy) state_d = NEXT;
      end
      NEXT: begin
        if (sec_cnt_q < SECTORS_PER_FRAME - 16'd1) begin
          sec_cnt_d = sec_cnt_q + 16'd1;
          rd_addr_d = rd_addr_q + 32'd1;
          state_d   = ISSUE;
        end else begin
          frame_done_d = 1'b1;
`ifdef SD_RD_LOOP_EN
          frame_idx_d = last_frame ? 8'd0 : frame_idx_q + 8'd1;
          state_d     = GAP;
`else
          if (last_frame) begin
            state_d = DONE;
          end else begin
            frame_idx_d = frame_idx_q + 8'd1;
            state_d     = GAP;
          end
`endif
        end
      end
      GAP: begin
        if (!play_en)        state_d = IDLE;
        else if (req_pend_q) state_d = FRAME_START;
      end
      DONE: begin
        if (!play_en) begin
          state_d     = IDLE;
          frame_idx_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame setup happens on the edge into FRAME_START so the new pic_c and
    // base address are already visible during that cycle; this gives the
    // read engine two cycles to restart its counters before the first rd_en.
    if (state_d == FRAME_START) begin
      pic_c_d    = ~pic_c_q;
      rd_addr_d  = frame_base(START_SECTOR, frame_idx_q, FRAME_STRIDE);
      sec_cnt_d  = 16'd0;
      req_pend_d = 1'b0;
    end

    // A request landing on the consuming edge is kept for the next frame.
    if (frame_req) req_pend_d = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      rd_addr_q    <= START_SECTOR;
      sec_cnt_q    <= 16'd0;
      frame_idx_q  <= 8'd0;
      pic_c_q      <= 1'b0;
      frame_done_q <= 1'b0;
      req_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      sec_cnt_q    <= sec_cnt_d;
      frame_idx_q  <= frame_idx_d;
      pic_c_q      <= pic_c_d;
      frame_done_q <= frame_done_d;
      req_pend_q   <= req_pend_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign pic_c      = pic_c_q;
  assign frame_idx  = frame_idx_q;
  assign frame_done = frame_done_q;
  assign ctrl_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sd_frame_rd_ctrl.sv
// Purpose: directed self-checking bench for sd_frame_rd_ctrl (4-sector frames, 2 frames).
// Latency: read-engine model raises rd_busy 1 cycle after rd_en, for 20 cycles.
// Backpressure: fifo_afull driven directly by the scenario tasks.
module tb_sd_frame_rd_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_end = 1'b0;
  logic        play_en = 1'b0;
  logic        frame_req = 1'b0;
  logic        fifo_afull = 1'b0;
  logic        rd_busy = 1'b0;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        pic_c;
  logic [7:0]  frame_idx;
  logic        frame_done;
  logic        ctrl_busy;

  int total = 0;
  int bad   = 0;

  // Monitor state (written only by the monitor process).
  int          cyc = 0;
  int          en_cnt = 0;
  int          fd_cnt = 0;
  int          toggles = 0;
  int          tog_cyc = 0;
  logic        pic_prev = 1'b0;
  logic [31:0] addr_q[$];
  int          en_cyc[$];

  // Read-engine model state (written only by the model process, except ign_req).
  int busy_left = 0;
  bit busy_pend = 1'b0;
  int ign_req = 0;
  int ign_done = 0;

  always #10 sys_clk = ~sys_clk;

  sd_frame_rd_ctrl #(
    .START_SECTOR      (32'h0000_4000),
    .SECTORS_PER_FRAME (16'd4),
    .FRAME_STRIDE      (32'h0000_0100),
    .NUM_FRAMES        (8'd2),
    .ACK_TIMEOUT       (4'd8)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .init_end   (init_end),
    .play_en    (play_en),
    .frame_req  (frame_req),
    .fifo_afull (fifo_afull),
    .rd_busy    (rd_busy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .pic_c      (pic_c),
    .frame_idx  (frame_idx),
    .frame_done (frame_done),
    .ctrl_busy  (ctrl_busy)
  );

  always @(negedge sys_clk) begin
    cyc = cyc + 1;
    if (rd_en === 1'b1) begin
      en_cnt = en_cnt + 1;
      addr_q.push_back(rd_addr);
      en_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
    if (pic_c !== pic_prev) begin
      toggles = toggles + 1;
      tog_cyc = cyc;
    end
    pic_prev = pic_c;
  end

  // Read engine: busy from the cycle after rd_en for 20 cycles; may drop requests.
  initial begin
    forever begin
      @(posedge sys_clk);
      #2;
      if (!sys_rst_n) begin
        busy_pend = 1'b0;
        busy_left = 0;
        rd_busy   = 1'b0;
      end else begin
        if (busy_pend) begin
          rd_busy   = 1'b1;
          busy_left = 20;
          busy_pend = 1'b0;
        end else if (busy_left > 0) begin
          busy_left = busy_left - 1;
          if (busy_left == 0) rd_busy = 1'b0;
        end
        if (rd_en === 1'b1) begin
          if (ign_done < ign_req) ign_done = ign_done + 1;
          else                    busy_pend = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n  = 1'b0;
    init_end   = 1'b1;
    play_en    = 1'b1;
    frame_req  = 1'b0;
    fifo_afull = 1'b0;
    step();
    step();
    sys_rst_n = 1'b1;
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
  endtask

  task automatic wait_en(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (en_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_fd(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (fd_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  function automatic logic [31:0] get_addr(input int idx);
    return (addr_q.size() > idx) ? addr_q[idx] : 32'hDEAD_DEAD;
  endfunction

  function automatic int get_cyc(input int idx);
    return (en_cyc.size() > idx) ? en_cyc[idx] : -1000;
  endfunction

  task automatic test_reset();
    sys_rst_n = 1'b0;
    init_end  = 1'b1;
    play_en   = 1'b1;
    step();
    step();
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
    total++; if (rd_addr !== 32'h4000) begin bad++; $display("FAIL reset_rd_addr got=%h want=4000", rd_addr); end
    total++; if (pic_c !== 1'b0) begin bad++; $display("FAIL reset_pic_c got=%b want=0", pic_c); end
    total++; if (frame_idx !== 8'd0) begin bad++; $display("FAIL reset_frame_idx got=%0d want=0", frame_idx); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    total++; if (ctrl_busy !== 1'b0) begin bad++; $display("FAIL reset_ctrl_busy got=%b want=0", ctrl_busy); end
    sys_rst_n = 1'b1;
    step();
    step();
    // No frame_req yet: must stay idle.
    total++; if (ctrl_busy !== 1'b0) begin bad++; $display("FAIL idle_no_req got=%b want=0", ctrl_busy); end
  endtask

  task automatic test_single_frame();
    int eb, fb, tb;
    bit ok;
    do_reset();
    eb = en_cnt; fb = fd_cnt; tb = toggles;
    pulse_req();
    wait_fd(fb + 1, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_frame_done_timeout got=%0d want=%0d", fd_cnt - fb, 1); end
    step();
    step();
    total++; if (en_cnt - eb !== 4) begin bad++; $display("FAIL single_rd_en_count got=%0d want=4", en_cnt - eb); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (get_addr(eb + k) !== 32'h4000 + k) begin
        bad++; $display("FAIL single_addr%0d got=%h want=%h", k, get_addr(eb + k), 32'h4000 + k);
      end
    end
    total++; if (toggles - tb !== 1) begin bad++; $display("FAIL single_pic_toggles got=%0d want=1", toggles - tb); end
    total++; if (pic_c !== 1'b1) begin bad++; $display("FAIL single_pic_c got=%b want=1", pic_c); end
    total++; if (get_cyc(eb) - tog_cyc !== 2) begin bad++; $display("FAIL first_en_after_toggle got=%0d want=2", get_cyc(eb) - tog_cyc); end
    total++; if (fd_cnt - fb !== 1) begin bad++; $display("FAIL single_frame_done_count got=%0d want=1", fd_cnt - fb); end
    total++; if (frame_idx !== 8'd1) begin bad++; $display("FAIL single_frame_idx got=%0d want=1", frame_idx); end
    total++; if (ctrl_busy !== 1'b1) begin bad++; $display("FAIL single_gap_busy got=%b want=1", ctrl_busy); end
  endtask

  task automatic test_backpressure();
    int eb, fb;
    bit ok;
    do_reset();
    eb = en_cnt; fb = fd_cnt;
    pulse_req();
    wait_en(eb + 2, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_second_en_timeout got=%0d want=2", en_cnt - eb); end
    fifo_afull = 1'b1;
    for (int i = 0; i < 50; i++) step();
    total++; if (en_cnt - eb !== 2) begin bad++; $display("FAIL bp_no_en_during_hold got=%0d want=2", en_cnt - eb); end
    fifo_afull = 1'b0;
    step();
    total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL bp_en_after_release got=%b want=1", rd_en); end
    total++; if (rd_addr !== 32'h4002) begin bad++; $display("FAIL bp_addr_after_release got=%h want=4002", rd_addr); end
    wait_fd(fb + 1, 400, ok);
    step();
    total++; if (en_cnt - eb !== 4) begin bad++; $display("FAIL bp_total_en got=%0d want=4", en_cnt - eb); end
    total++; if (get_addr(eb + 3) !== 32'h4003) begin bad++; $display("FAIL bp_last_addr got=%h want=4003", get_addr(eb + 3)); end
  endtask

  task automatic test_ack_timeout();
    int eb, fb;
    bit ok;
    do_reset();
    eb = en_cnt; fb = fd_cnt;
    ign_req = ign_done + 1;
    pulse_req();
    wait_en(eb + 2, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_reissue_timeout got=%0d want=2", en_cnt - eb); end
    // 8 cycles in WAIT_ACK plus one ISSUE cycle between the two requests.
    total++; if (get_cyc(eb + 1) - get_cyc(eb) !== 9) begin bad++; $display("FAIL to_spacing got=%0d want=9", get_cyc(eb + 1) - get_cyc(eb)); end
    total++; if (get_addr(eb + 1) !== 32'h4000) begin bad++; $display("FAIL to_reissue_addr got=%h want=4000", get_addr(eb + 1)); end
    wait_fd(fb + 1, 400, ok);
    step();
    total++; if (en_cnt - eb !== 5) begin bad++; $display("FAIL to_total_en got=%0d want=5", en_cnt - eb); end
    total++; if (get_addr(eb + 2) !== 32'h4001) begin bad++; $display("FAIL to_next_addr got=%h want=4001", get_addr(eb + 2)); end
    total++; if (get_addr(eb + 4) !== 32'h4003) begin bad++; $display("FAIL to_last_addr got=%h want=4003", get_addr(eb + 4)); end
  endtask

  task automatic test_multi_frame();
    int eb, fb, tb;
    bit ok;
    do_reset();
    eb = en_cnt; fb = fd_cnt; tb = toggles;
    pulse_req();
    wait_fd(fb + 1, 400, ok);
    pulse_req();
    wait_fd(fb + 2, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL mf_two_frames_timeout got=%0d want=2", fd_cnt - fb); end
    step();
    total++; if (get_addr(eb + 4) !== 32'h4100) begin bad++; $display("FAIL mf_frame1_base got=%h want=4100", get_addr(eb + 4)); end
    total++; if (get_addr(eb + 7) !== 32'h4103) begin bad++; $display("FAIL mf_frame1_last got=%h want=4103", get_addr(eb + 7)); end
    pulse_req();
`ifdef SD_RD_LOOP_EN
    wait_fd(fb + 3, 400, ok);
    step();
    total++; if (en_cnt - eb !== 12) begin bad++; $display("FAIL mf_loop_en_count got=%0d want=12", en_cnt - eb); end
    total++; if (get_addr(eb + 8) !== 32'h4000) begin bad++; $display("FAIL mf_loop_base got=%h want=4000", get_addr(eb + 8)); end
    total++; if (toggles - tb !== 3) begin bad++; $display("FAIL mf_loop_toggles got=%0d want=3", toggles - tb); end
    total++; if (frame_idx !== 8'd1) begin bad++; $display("FAIL mf_loop_frame_idx got=%0d want=1", frame_idx); end
`else
    for (int i = 0; i < 100; i++) step();
    total++; if (en_cnt - eb !== 8) begin bad++; $display("FAIL mf_done_en_count got=%0d want=8", en_cnt - eb); end
    total++; if (toggles - tb !== 2) begin bad++; $display("FAIL mf_done_toggles got=%0d want=2", toggles - tb); end
    total++; if (frame_idx !== 8'd1) begin bad++; $display("FAIL mf_done_frame_idx got=%0d want=1", frame_idx); end
    total++; if (ctrl_busy !== 1'b1) begin bad++; $display("FAIL mf_done_busy got=%b want=1", ctrl_busy); end
    play_en = 1'b0;
    step();
    step();
    total++; if (frame_idx !== 8'd0) begin bad++; $display("FAIL mf_play_off_frame_idx got=%0d want=0", frame_idx); end
    total++; if (ctrl_busy !== 1'b0) begin bad++; $display("FAIL mf_play_off_idle got=%b want=0", ctrl_busy); end
`endif
  endtask

  task automatic test_reset_mid();
    int eb;
    bit ok;
    do_reset();
    eb = en_cnt;
    pulse_req();
    wait_en(eb + 1, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL rm_first_en_timeout got=%0d want=1", en_cnt - eb); end
    step();
    step();
    // Now inside WAIT_DONE with the sector in flight.
    total++; if (ctrl_busy !== 1'b1 || pic_c !== 1'b1) begin bad++; $display("FAIL rm_pre_state got=%b%b want=11", ctrl_busy, pic_c); end
    sys_rst_n = 1'b0;
    step();
    total++; if (ctrl_busy !== 1'b0) begin bad++; $display("FAIL rm_idle got=%b want=0", ctrl_busy); end
    total++; if (rd_addr !== 32'h4000) begin bad++; $display("FAIL rm_rd_addr got=%h want=4000", rd_addr); end
    total++; if (pic_c !== 1'b0) begin bad++; $display("FAIL rm_pic_c got=%b want=0", pic_c); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL rm_rd_en got=%b want=0", rd_en); end
    sys_rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_ack_timeout();
    test_multi_frame();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
